// File: rtl/serial_nibble_subtractor_if.sv
// Operand/result bundle for the bit-serial subtractor.
// The master drives the start request and operands; the slave returns the result.
interface serial_nibble_subtractor_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             ready;
  logic [WIDTH-1:0] d;
  logic             bout;
  logic             ovf;
  logic             valid;

  modport master (
    output start, a, b, bin,
    input  ready, d, bout, ovf, valid
  );

  modport slave (
    input  start, a, b, bin,
    output ready, d, bout, ovf, valid
  );
endinterface

// File: rtl/serial_nibble_subtractor.sv
// Bit-serial subtractor d = a - b - bin, LSB first, one bit per clock.
// Result, borrow-out and signed overflow are held in output registers and qualified by valid.
module serial_nibble_subtractor #(
  parameter int WIDTH = 4,
  parameter int CW    = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  serial_nibble_subtractor_if.slave  bus
);

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] RUN  = 2'b01;
  localparam logic [1:0] DONE = 2'b10;

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             br_q, br_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;
  logic             valid_q, valid_d;

  logic             diff_bit;
  logic             br_next;
  logic [WIDTH-1:0] res_shift;

  // Operands shift right so the bit under process is always at index 0.
  assign diff_bit  = a_q[0] ^ b_q[0] ^ br_q;
  assign br_next   = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
  assign res_shift = {diff_bit, res_q[WIDTH-1:1]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    br_d    = br_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    d_d     = d_q;
    bout_d  = bout_q;
    ovf_d   = ovf_q;
    valid_d = valid_q;

    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          br_d    = bus.bin;
          cnt_d   = '0;
          res_d   = '0;
          valid_d = 1'b0;
          state_d = RUN;
        end
      end

      RUN: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        res_d = res_shift;
        br_d  = br_next;
        if (cnt_q == LAST) begin
          // br_q here is the borrow into the MSB; its XOR with the borrow out is signed overflow.
          d_d     = res_shift;
          bout_d  = br_next;
          ovf_d   = br_q ^ br_next;
          valid_d = 1'b1;
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      d_q     <= '0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      d_q     <= d_d;
      bout_q  <= bout_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
    end
  end

  assign bus.ready = (state_q == IDLE) || (state_q == DONE);
  assign bus.d     = d_q;
  assign bus.bout  = bout_q;
  assign bus.ovf   = ovf_q;
  assign bus.valid = valid_q;

endmodule

// File: tb/tb_serial_nibble_subtractor.sv
// Directed bench for serial_nibble_subtractor: table of operand/result vectors plus
// hand-written handshake and reset sequences.
module tb_serial_nibble_subtractor;

  localparam int WIDTH = 4;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic [WIDTH-1:0] d;
    logic             bout;
    logic             ovf;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total  = 0;
  int   passed = 0;

  serial_nibble_subtractor_if #(.WIDTH(WIDTH)) bus ();

  serial_nibble_subtractor #(.WIDTH(WIDTH), .CW(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  // Called #1 after a rising edge; returns #1 after the edge that delivers the result.
  task automatic run_vec(input vec_t v, input logic [WIDTH-1:0] prev_d);
    bus.start = 1'b1;
    bus.a     = v.a;
    bus.b     = v.b;
    bus.bin   = v.bin;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.a     = ~v.a;
    bus.b     = ~v.b;
    bus.bin   = ~v.bin;
    chk("accept_valid_low", int'(bus.valid), 0);
    chk("run_ready_low", int'(bus.ready), 0);
    for (int k = 0; k < WIDTH - 1; k++) begin
      @(posedge clk); #1;
      chk("run_valid_low", int'(bus.valid), 0);
      chk("run_d_hold", int'(bus.d), int'(prev_d));
    end
    @(posedge clk); #1;
    chk("done_valid", int'(bus.valid), 1);
    chk("done_ready", int'(bus.ready), 1);
    chk("done_d", int'(bus.d), int'(v.d));
    chk("done_bout", int'(bus.bout), int'(v.bout));
    chk("done_ovf", int'(bus.ovf), int'(v.ovf));
  endtask

  vec_t vecs[8];
  vec_t v;
  logic [WIDTH-1:0] prev;

  initial begin
    vecs[0] = '{a: 4'h6, b: 4'h2, bin: 1'b0, d: 4'h4, bout: 1'b0, ovf: 1'b0};
    vecs[1] = '{a: 4'h3, b: 4'h9, bin: 1'b0, d: 4'hA, bout: 1'b1, ovf: 1'b1};
    vecs[2] = '{a: 4'h9, b: 4'h3, bin: 1'b0, d: 4'h6, bout: 1'b0, ovf: 1'b1};
    vecs[3] = '{a: 4'h0, b: 4'h0, bin: 1'b1, d: 4'hF, bout: 1'b1, ovf: 1'b0};
    vecs[4] = '{a: 4'h7, b: 4'h8, bin: 1'b0, d: 4'hF, bout: 1'b1, ovf: 1'b1};
    vecs[5] = '{a: 4'h8, b: 4'h1, bin: 1'b0, d: 4'h7, bout: 1'b0, ovf: 1'b1};
    vecs[6] = '{a: 4'hF, b: 4'hF, bin: 1'b0, d: 4'h0, bout: 1'b0, ovf: 1'b0};
    vecs[7] = '{a: 4'h5, b: 4'h5, bin: 1'b1, d: 4'hF, bout: 1'b1, ovf: 1'b0};

    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.bin   = 1'b0;

    #2;
    chk("rst_d", int'(bus.d), 0);
    chk("rst_bout", int'(bus.bout), 0);
    chk("rst_ovf", int'(bus.ovf), 0);
    chk("rst_valid", int'(bus.valid), 0);
    chk("rst_ready", int'(bus.ready), 1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("idle_ready", int'(bus.ready), 1);

    prev = '0;
    foreach (vecs[i]) begin
      run_vec(vecs[i], prev);
      prev = vecs[i].d;
    end

    // Start pulse during RUN must be ignored.
    bus.start = 1'b1; bus.a = 4'h3; bus.b = 4'h9; bus.bin = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.a = 4'h6; bus.b = 4'h2; bus.bin = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    chk("ign_valid_low", int'(bus.valid), 0);
    chk("ign_ready_low", int'(bus.ready), 0);
    @(posedge clk); #1;
    chk("ign_valid", int'(bus.valid), 1);
    chk("ign_d", int'(bus.d), 10);
    chk("ign_bout", int'(bus.bout), 1);
    chk("ign_ovf", int'(bus.ovf), 1);

    // DONE holds while start stays low.
    repeat (3) @(posedge clk);
    #1;
    chk("hold_valid", int'(bus.valid), 1);
    chk("hold_d", int'(bus.d), 10);
    chk("hold_ready", int'(bus.ready), 1);

    // Asynchronous reset two edges into RUN.
    bus.start = 1'b1; bus.a = 4'h6; bus.b = 4'h2; bus.bin = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("mid_rst_d", int'(bus.d), 0);
    chk("mid_rst_bout", int'(bus.bout), 0);
    chk("mid_rst_ovf", int'(bus.ovf), 0);
    chk("mid_rst_valid", int'(bus.valid), 0);
    chk("mid_rst_ready", int'(bus.ready), 1);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_valid", int'(bus.valid), 0);
    v = '{a: 4'h5, b: 4'h1, bin: 1'b0, d: 4'h4, bout: 1'b0, ovf: 1'b0};
    run_vec(v, 4'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/serial_nibble_subtractor.md
Name: serial_nibble_subtractor

Overview:
- Bit-serial subtractor computing d = a - b - bin, LSB first, one bit per clock, with a borrow flip-flop.
- It is the inverse operation of the ripple nibble adder and reuses the same `valid` semantics: output is trustworthy only when `valid` = 1.
- Operands are captured with a start/ready handshake. After WIDTH clocks it presents the difference, borrow-out and signed overflow.
- It sits beside the nibble adder in the ALU exercise set.

Parameters:
- WIDTH, 4, operand and result width in bits (≥ 2).
- CW, 3, counter width; must satisfy 2^CW > WIDTH.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- start  in  1  request to begin a subtraction; sampled at rising edge.
- a  in  WIDTH  minuend; captured when start is accepted.
- b  in  WIDTH  subtrahend; captured when start is accepted.
- bin  in  1  borrow in; captured when start is accepted.
- ready  out  1  high when a start will be accepted (IDLE or DONE).
- d  out  WIDTH  difference, registered.
- bout  out  1  borrow out; 1 when a < b + bin (unsigned).
- ovf  out  1  signed (two's complement) overflow of a - b - bin.
- valid  out  1  d, bout and ovf are final for the last accepted operands.

Behaviour:
- Reset (async, rst = 1): state = IDLE, counter = 0, borrow FF = 0, shift registers = 0, d = 0, bout = 0, ovf = 0, valid = 0, ready = 1.
- State IDLE: ready = 1, valid = 0. start = 1 at an edge → latch a, b, bin into internal registers; counter = 0; go to RUN.
- State RUN: ready = 0, valid = 0.
  - Each edge processes bit i = counter, using the latched operands only:
    - diff_i = a_i ^ b_i ^ br
    - br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br)
  - diff_i is shifted into the internal result register.
  - Before processing bit WIDTH-1, store br as br_msb_in.
  - counter increments. After the edge that processes bit WIDTH-1, go to DONE.
- State DONE: the same edge that leaves RUN loads the output registers:
  - d = result
  - bout = final br
  - ovf = br_msb_in ^ final br
  - valid = 1, ready = 1
- State DONE, holding: outputs hold while start = 0.
- State DONE, new start: start = 1 is accepted exactly as in IDLE. valid drops at that same edge, and the state goes to RUN.
- Latency: start sampled high at edge N → valid = 1 after edge N+WIDTH. Back-to-back throughput is one result per WIDTH+1 cycles.
- Output registers during RUN: d, bout and ovf keep the previous result. They change only on entry to DONE. Consumers must qualify them with valid.
- start while in RUN is ignored: no restart, no re-latch, completion timing unchanged.
- Input changes on a, b or bin after acceptance have no effect until the next accepted start.
- Wrap-around: arithmetic is modulo 2^WIDTH. bout reports the unsigned underflow; ovf reports the signed overflow.
- Reset mid-RUN: abort immediately to the reset values. No partial result ever appears on d.
- Counter never exceeds WIDTH-1. There are no other states; any illegal encoding returns to IDLE on the next edge.

Test Plan:
- Reset: assert rst asynchronously mid-cycle → d = 0, bout = 0, ovf = 0, valid = 0, ready = 1 without waiting for a clk edge.
- Basic: a = 6, b = 2, bin = 0, start one cycle → valid rises exactly 4 edges later (WIDTH = 4); d = 4, bout = 0, ovf = 0; ready = 0 during the 4 RUN edges.
- Underflow with signed overflow: a = 3, b = 9, bin = 0 → d = 0xA, bout = 1, ovf = 1.
  - Then a = 9, b = 3 → d = 6, bout = 0, ovf = 1.
- Borrow-in wrap: a = 0, b = 0, bin = 1 → d = 0xF, bout = 1, ovf = 0.
- Handshake:
  - Pulse start again during RUN with different operands → ignored; the first result is delivered on time.
  - Start in DONE → valid falls at the accepting edge; the new result appears WIDTH edges later; d holds the old value meanwhile.
- Reset mid-RUN: rst after 2 RUN edges → immediate IDLE with zeroed outputs; a following start with a = 5, b = 1 yields d = 4, bout = 0, ovf = 0 after 4 edges.
